// File: rtl/pc_sequencer.sv
// Program-counter sequencer: stall / return / call / jump / branch / sequential next-PC selection.
// Optional return-address stack is enabled by defining PC_SEQ_RAS_EN; without it call behaves as jump.
module pc_sequencer #(
  parameter int PC_W      = 16,
  parameter int STEP      = 2,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_off,
  input  logic            jump_en,
  input  logic            call_en,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            ret_en,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PCnext,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RET,
    OP_CALL,
    OP_JUMP,
    OP_BRANCH,
    OP_SEQ
  } op_e;

  op_e             op;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] ras_top;

  assign seq_pc = PC + PC_W'(STEP);

  // Strict priority decode; lower-priority requests in the same cycle are dropped.
  always_comb begin
    op = OP_SEQ;
    if (stall) begin
      op = OP_HOLD;
`ifdef PC_SEQ_RAS_EN
    end else if (ret_en) begin
      op = OP_RET;
    end else if (call_en) begin
      op = OP_CALL;
`else
    end else if (call_en) begin
      op = OP_JUMP;
`endif
    end else if (jump_en) begin
      op = OP_JUMP;
    end else if (branch_en) begin
      op = OP_BRANCH;
    end
  end

  always_comb begin
    PCnext = seq_pc;
    case (op)
      OP_HOLD:   PCnext = PC;
      OP_RET:    PCnext = ras_empty ? seq_pc : ras_top;
      OP_CALL:   PCnext = jump_addr;
      OP_JUMP:   PCnext = jump_addr;
      OP_BRANCH: PCnext = PC + branch_off;
      default:   PCnext = seq_pc;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      PC <= PC_W'(RESET_PC);
    end else begin
      PC <= PCnext;
    end
  end

`ifdef PC_SEQ_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  logic             err_next;

  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_W'(RAS_DEPTH));
  assign ras_top   = ras_mem[wr_ptr - PTR_W'(1)];
  assign do_push   = (op == OP_CALL);
  assign do_pop    = (op == OP_RET) && !ras_empty;
  assign err_next  = (do_push && ras_full) || ((op == OP_RET) && ras_empty);

  // wr_ptr is the next free slot; when full it also addresses the oldest entry,
  // so a push on a full stack overwrites the oldest return address.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      count   <= '0;
      ras_err <= 1'b0;
    end else begin
      ras_err <= err_next;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!ras_full) begin
          count <= count + CNT_W'(1);
        end
      end else if (do_pop) begin
        wr_ptr <= wr_ptr - PTR_W'(1);
        count  <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      ras_mem[wr_ptr] <= seq_pc;
    end
  end
`else
  localparam int unused_depth = RAS_DEPTH;
  logic unused_ret;

  assign unused_ret = ret_en;
  assign ras_top    = seq_pc;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the next-PC and return-stack rules.
module tb_pc_sequencer;
  localparam int PC_W  = 16;
  localparam int STEP  = 2;
  localparam int DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall = 1'b0;
  logic            branch_en = 1'b0;
  logic [PC_W-1:0] branch_off = '0;
  logic            jump_en = 1'b0;
  logic            call_en = 1'b0;
  logic [PC_W-1:0] jump_addr = '0;
  logic            ret_en = 1'b0;
  logic [PC_W-1:0] PC;
  logic [PC_W-1:0] PCnext;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_err;

  pc_sequencer #(.PC_W(PC_W), .STEP(STEP), .RESET_PC(0), .RAS_DEPTH(DEPTH)) dut (
    .CLK(CLK), .rst_n(rst_n), .stall(stall), .branch_en(branch_en), .branch_off(branch_off),
    .jump_en(jump_en), .call_en(call_en), .jump_addr(jump_addr), .ret_en(ret_en),
    .PC(PC), .PCnext(PCnext), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural PC, stack as a queue (back = top), error flag.
  logic [PC_W-1:0] m_pc = '0;
  logic [PC_W-1:0] exp_next;
  logic [PC_W-1:0] ras_q[$];
  bit              m_err = 1'b0;

  task automatic model_reset();
    m_pc = '0;
    ras_q.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit commit);
    logic [PC_W-1:0] n;
    bit e;
    n = m_pc + PC_W'(STEP);
    e = 1'b0;
    if (stall) begin
      n = m_pc;
    end else if (RAS && ret_en) begin
      if (ras_q.size() > 0) begin
        n = ras_q[$];
        if (commit) void'(ras_q.pop_back());
      end else begin
        e = 1'b1;
      end
    end else if (call_en) begin
      n = jump_addr;
      if (RAS) begin
        e = (ras_q.size() == DEPTH);
        if (commit) begin
          ras_q.push_back(m_pc + PC_W'(STEP));
          if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
        end
      end
    end else if (jump_en) begin
      n = jump_addr;
    end else if (branch_en) begin
      n = m_pc + branch_off;
    end
    exp_next = n;
    if (commit) begin
      m_pc = n;
      m_err = e;
    end
  endtask

  task automatic drive(input bit st, input bit rt, input bit cl, input bit jp, input bit br,
                       input logic [PC_W-1:0] addr, input logic [PC_W-1:0] off);
    stall = st; ret_en = rt; call_en = cl; jump_en = jp; branch_en = br;
    jump_addr = addr; branch_off = off;
    #1;
    model_step(1'b0);
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
    model_step(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, '0, '0);
    tests++; if (PC !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h exp 0000", PC); end
    tests++; if (ras_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", ras_empty); end
    tests++; if (ras_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", ras_full); end
    tests++; if (ras_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", ras_err); end
    @(negedge CLK);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 0, 0, '0, '0);
      tests++; if (PCnext !== 16'(2 * i)) begin fails++; $display("FAIL seq_pcnext got %h exp %h", PCnext, 16'(2 * i)); end
      cycle();
      tests++; if (PC !== 16'(2 * i)) begin fails++; $display("FAIL seq_pc got %h exp %h", PC, 16'(2 * i)); end
    end
  endtask

  task automatic test_branch_wrap();
    drive(0, 0, 0, 1, 0, 16'h0080, '0);
    cycle();
    drive(0, 0, 0, 0, 1, '0, 16'hFFFC);
    tests++; if (PCnext !== 16'd124) begin fails++; $display("FAIL branch_pcnext got %h exp 007c", PCnext); end
    cycle();
    tests++; if (PC !== 16'd124) begin fails++; $display("FAIL branch_pc got %h exp 007c", PC); end
    drive(0, 0, 0, 1, 0, 16'hFFFE, '0);
    cycle();
    drive(0, 0, 0, 0, 0, '0, '0);
    cycle();
    tests++; if (PC !== 16'h0000) begin fails++; $display("FAIL wrap_pc got %h exp 0000", PC); end
  endtask

  task automatic test_call_ret();
    drive(0, 0, 0, 1, 0, 16'h0010, '0);
    cycle();
    drive(0, 0, 1, 0, 0, 16'h0200, '0);
    cycle();
    tests++; if (PC !== 16'h0200) begin fails++; $display("FAIL call_pc got %h exp 0200", PC); end
    tests++; if (ras_empty !== !RAS) begin fails++; $display("FAIL call_empty got %b exp %b", ras_empty, !RAS); end
    drive(0, 1, 0, 0, 0, '0, '0);
    cycle();
    tests++; if (PC !== (RAS ? 16'h0012 : 16'h0202)) begin fails++; $display("FAIL ret_pc got %h exp %h", PC, RAS ? 16'h0012 : 16'h0202); end
    tests++; if (ras_empty !== 1'b1) begin fails++; $display("FAIL ret_empty got %b exp 1", ras_empty); end
  endtask

  task automatic test_overflow();
    drive(0, 0, 0, 1, 0, 16'h1000, '0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 0, 16'(16'h2000 + i * 16'h0100), '0);
      cycle();
      tests++; if (PC !== m_pc || ras_full !== (ras_q.size() == DEPTH) || ras_err !== m_err) begin
        fails++; $display("FAIL ovf_call%0d got pc=%h full=%b err=%b exp pc=%h full=%b err=%b",
                          i, PC, ras_full, ras_err, m_pc, ras_q.size() == DEPTH, m_err);
      end
    end
    tests++; if (ras_err !== RAS) begin fails++; $display("FAIL ovf_err got %b exp %b", ras_err, RAS); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, '0, '0);
      cycle();
      tests++; if (PC !== m_pc || ras_empty !== (ras_q.size() == 0) || ras_err !== m_err) begin
        fails++; $display("FAIL ovf_ret%0d got pc=%h empty=%b err=%b exp pc=%h empty=%b err=%b",
                          i, PC, ras_empty, ras_err, m_pc, ras_q.size() == 0, m_err);
      end
    end
    tests++; if (ras_err !== RAS) begin fails++; $display("FAIL unf_err got %b exp %b", ras_err, RAS); end
  endtask

  task automatic test_stall_priority();
    logic [PC_W-1:0] held;
    drive(0, 0, 1, 0, 0, 16'h0700, '0);
    cycle();
    held = PC;
    drive(1, 1, 0, 1, 0, 16'h5555, '0);
    tests++; if (PCnext !== held) begin fails++; $display("FAIL stall_pcnext got %h exp %h", PCnext, held); end
    cycle();
    tests++; if (PC !== held || ras_empty !== (ras_q.size() == 0) || ras_err !== 1'b0) begin
      fails++; $display("FAIL stall_hold got pc=%h empty=%b err=%b exp pc=%h empty=%b err=0",
                        PC, ras_empty, ras_err, held, ras_q.size() == 0);
    end
    drive(0, 1, 0, 1, 0, 16'h5555, '0);
    cycle();
    tests++; if (PC !== m_pc) begin fails++; $display("FAIL ret_over_jump got %h exp %h", PC, m_pc); end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 1, 0, 16'h0040, '0);
    cycle();
    tests++; if (PC !== 16'h0040) begin fails++; $display("FAIL pre_reset_pc got %h exp 0040", PC); end
    drive(0, 0, 1, 0, 0, 16'h0300, '0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++; if (PC !== 16'h0000 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
      fails++; $display("FAIL async_reset got pc=%h empty=%b err=%b exp pc=0000 empty=1 err=0", PC, ras_empty, ras_err);
    end
    drive(0, 0, 0, 0, 0, '0, '0);
    @(negedge CLK);
    rst_n = 1'b1;
    cycle();
    tests++; if (PC !== 16'h0002 || ras_empty !== 1'b1) begin
      fails++; $display("FAIL post_reset got pc=%h empty=%b exp pc=0002 empty=1", PC, ras_empty);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            16'($urandom), 16'($urandom));
      tests++; if (PCnext !== exp_next) begin fails++; $display("FAIL rand_pcnext[%0d] got %h exp %h", i, PCnext, exp_next); end
      cycle();
      tests++; if (PC !== m_pc || ras_empty !== (ras_q.size() == 0) || ras_full !== (ras_q.size() == DEPTH) || ras_err !== m_err) begin
        fails++; $display("FAIL rand_state[%0d] got pc=%h e=%b f=%b err=%b exp pc=%h e=%b f=%b err=%b", i,
                          PC, ras_empty, ras_full, ras_err, m_pc, ras_q.size() == 0, ras_q.size() == DEPTH, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch_wrap();
    test_call_ret();
    test_overflow();
    test_stall_priority();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 16, width of program counter and all address ports.
REQ-002 Parameter STEP, default 2, sequential increment added to PC each advancing cycle.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 CLK  in  1  single clock, all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 stall  in  1  hold PC and stack unchanged this cycle.
REQ-008 branch_en  in  1  PC-relative branch request.
REQ-009 branch_off  in  PC_W  signed two's-complement offset added to current PC.
REQ-010 jump_en  in  1  absolute jump request.
REQ-011 call_en  in  1  call request: jump to jump_addr and push return address.
REQ-012 jump_addr  in  PC_W  absolute target for jump/call.
REQ-013 ret_en  in  1  return request: pop stack into PC.
REQ-014 PC  out  PC_W  registered current program counter.
REQ-015 PCnext  out  PC_W  combinational value PC will take at next edge.
REQ-016 ras_empty  out  1  stack holds zero entries.
REQ-017 ras_full  out  1  stack holds RAS_DEPTH entries.
REQ-018 ras_err  out  1  registered one-cycle pulse on stack overflow or underflow.

Function
REQ-019 Next-PC priority, highest first: stall, ret_en, call_en, jump_en, branch_en, sequential; lower requests in the same cycle are ignored.
REQ-020 stall=1: PCnext=PC, stack pointer and contents unchanged, ras_err next cycle 0.
REQ-021 Sequential: PCnext=PC+STEP.
REQ-022 Branch: PCnext=PC+branch_off.
REQ-023 Jump: PCnext=jump_addr.
REQ-024 Call: PCnext=jump_addr; PC+STEP pushed at same edge.
REQ-025 Return, stack non-empty: PCnext=top entry; entry popped at same edge.
REQ-026 All PC arithmetic is modulo 2^PC_W; carry discarded, wrap from all-ones to low values is legal and silent.
REQ-027 PC updates one edge after request sampled; PCnext reflects request in the same cycle (zero latency).
REQ-028 Call with stack full: oldest entry overwritten (circular), depth stays RAS_DEPTH, ras_full stays 1, ras_err pulses 1 next cycle.
REQ-029 Return with stack empty: PCnext=PC+STEP, stack unchanged, ras_err pulses 1 next cycle.
REQ-030 Stack occupancy counts 0..RAS_DEPTH; ras_empty/ras_full derived combinationally from count.

Reset
REQ-031 rst_n low asynchronously forces PC=RESET_PC, stack count=0, ras_err=0, independent of CLK.
REQ-032 Reset asserted mid-call or mid-return discards the pending operation; stack contents need not be cleared but are unreachable.
REQ-033 After rst_n rises, first edge applies normal priority rules.

Configuration
REQ-034 Macro PC_SEQ_RAS_EN defined: return-address stack, call_en, ret_en, ras_* behave per REQ-024..REQ-030.
REQ-035 Macro PC_SEQ_RAS_EN undefined: no stack storage; call_en acts as jump_en, ret_en ignored (sequential), ras_empty=1, ras_full=0, ras_err=0 constant.

Verification
REQ-036 Reset then 3 unstalled cycles, defaults -> PC = 0, 2, 4, 6.
REQ-037 PC=128, branch_off=-4 (0xFFFC) -> PC=124; PC=0xFFFE sequential -> PC=0x0000.
REQ-038 PC=0x0010, call jump_addr=0x0200, then ret -> PC=0x0200 then 0x0012, ras_empty 0 then 1.
REQ-039 Five calls with RAS_DEPTH=4 -> fifth sets ras_err pulse, ras_full=1; four returns yield last four return addresses, fifth return pulses ras_err, PC+=2.
REQ-040 stall=1 with jump_en and ret_en asserted -> PC and ras count unchanged; simultaneous ret_en and jump_en without stall -> return wins.
REQ-041 rst_n dropped between edges with PC=0x0040 -> PC=0x0000 immediately, ras_empty=1; macro undefined, call 0x0300 -> PC=0x0300, ras_empty stays 1.
